lfsr_stream_checker: RTL and testbench

- Far-end receiver for the team's XNOR-feedback LFSR serial stream, i.e. the bit the generator exposes as bit 0 of its LFSR data on each enabled cycle.
- Self-synchronises with no shared seed: loads its model register from the first NUM_BITS received bits, then predicts every later bit with the same feedback polynomial and compares.
- Counts mispredictions and raises a sticky tamper alarm for the security monitor.
- Sits at the return end of a shield/tamper line, or on a chip-to-chip link fed by the generator.

---
 rtl/lfsr_stream_checker.sv | 182 ++++++++++++++++++
 tb/tb_lfsr_stream_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker.sv
// rtl/lfsr_stream_checker.sv - self-synchronising receiver/checker for the XNOR-feedback LFSR serial stream
//
// Loads a model register from the first NUM_BITS received bits, then predicts
// each later bit with the generator's feedback polynomial. Mispredictions are
// counted; reaching ERR_THRESH raises a sticky tamper alarm.
//
// Optional feature macro: LFSR_RESYNC_EN
//   defined   - the first threshold hit after leaving IDLE triggers a reload
//               (resync) instead of an alarm; the second hit raises the alarm.
//   undefined - every threshold hit raises the alarm directly.
//
// Ports:
//   i_Clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_Enable     checker enable; low forces IDLE unless in ALARM
//   i_bit_valid  i_bit carries a stream bit this cycle
//   i_bit        received stream bit
//   i_clear      alarm acknowledge; returns ALARM to IDLE
//   o_locked     model register loaded and tracking
//   o_alarm      sticky tamper alarm
//   o_miss_cnt   mispredictions since last load (saturating)
//   o_LFSR_Data  model register, bit 0 = newest bit

module lfsr_stream_checker #(
    parameter int NUM_BITS   = 16,
    parameter int ERR_THRESH = 4,
    parameter int MISS_W     = 8
) (
    input  logic                i_Clk,
    input  logic                i_rst_n,
    input  logic                i_Enable,
    input  logic                i_bit_valid,
    input  logic                i_bit,
    input  logic                i_clear,
    output logic                o_locked,
    output logic                o_alarm,
    output logic [MISS_W-1:0]   o_miss_cnt,
    output logic [NUM_BITS-1:0] o_LFSR_Data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_ALARM  = 2'd3;

    localparam int                CNT_W     = $clog2(NUM_BITS + 1);
    localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(NUM_BITS - 1);
    localparam logic [MISS_W-1:0] THRESH    = MISS_W'(ERR_THRESH);

    logic [1:0]          state;
    logic [NUM_BITS:1]   r;
    logic [CNT_W-1:0]    ld_cnt;
    logic                pred;
    logic [NUM_BITS:1]   r_load;
    logic [NUM_BITS:1]   r_fly;
    logic [MISS_W-1:0]   miss_inc;
    logic                mismatch;

`ifdef LFSR_RESYNC_EN
    logic                resync_used;
`endif

    // Tap sets match the generator exactly; chained XNOR of four taps equals
    // the inverted XOR of all four.
    generate
        if (NUM_BITS == 8) begin : g_taps8
            assign pred = ~(r[8] ^ r[6] ^ r[5] ^ r[4]);
        end else if (NUM_BITS == 16) begin : g_taps16
            assign pred = ~(r[16] ^ r[15] ^ r[13] ^ r[4]);
        end else if (NUM_BITS == 32) begin : g_taps32
            assign pred = ~(r[32] ^ r[22] ^ r[2] ^ r[1]);
        end else begin : g_bad_width
            $error("lfsr_stream_checker: NUM_BITS must be 8, 16 or 32");
            assign pred = 1'b0;
        end

        if (ERR_THRESH < 1 || ERR_THRESH > 255 || ERR_THRESH > (2 ** MISS_W) - 1) begin : g_bad_thresh
            $error("lfsr_stream_checker: ERR_THRESH out of range for MISS_W");
        end
    endgenerate

    // Loading shifts in what arrived; tracking shifts in what was predicted so
    // a corrupted bit never pollutes later predictions.
    assign r_load   = {r[NUM_BITS-1:1], i_bit};
    assign r_fly    = {r[NUM_BITS-1:1], pred};
    assign miss_inc = (o_miss_cnt == '1) ? o_miss_cnt : o_miss_cnt + MISS_W'(1);
    assign mismatch = (i_bit != pred);

    assign o_LFSR_Data = r;

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            r          <= '0;
            ld_cnt     <= '0;
            o_miss_cnt <= '0;
            o_locked   <= 1'b0;
            o_alarm    <= 1'b0;
`ifdef LFSR_RESYNC_EN
            resync_used <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ld_cnt     <= '0;
                    o_miss_cnt <= '0;
`ifdef LFSR_RESYNC_EN
                    resync_used <= 1'b0;
`endif
                    if (i_Enable) begin
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (!i_Enable) begin
                        state      <= ST_IDLE;
                        ld_cnt     <= '0;
                        o_miss_cnt <= '0;
                    end else if (i_bit_valid) begin
                        r <= r_load;
                        if (ld_cnt == LOAD_LAST) begin
                            ld_cnt <= '0;
                            // All-ones is the XNOR lock-up state: the line is stuck high.
                            if (&r_load) begin
                                state   <= ST_ALARM;
                                o_alarm <= 1'b1;
                            end else begin
                                state    <= ST_LOCKED;
                                o_locked <= 1'b1;
                            end
                        end else begin
                            ld_cnt <= ld_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_LOCKED: begin
                    if (!i_Enable) begin
                        state      <= ST_IDLE;
                        o_locked   <= 1'b0;
                        ld_cnt     <= '0;
                        o_miss_cnt <= '0;
                    end else if (i_bit_valid) begin
                        r <= r_fly;
                        if (mismatch) begin
                            o_miss_cnt <= miss_inc;
                            if (miss_inc == THRESH) begin
                                o_locked <= 1'b0;
`ifdef LFSR_RESYNC_EN
                                if (!resync_used) begin
                                    resync_used <= 1'b1;
                                    state       <= ST_LOAD;
                                    o_miss_cnt  <= '0;
                                    ld_cnt      <= '0;
                                end else begin
                                    state   <= ST_ALARM;
                                    o_alarm <= 1'b1;
                                end
`else
                                state   <= ST_ALARM;
                                o_alarm <= 1'b1;
`endif
                            end
                        end
                    end
                end

                default: begin
                    // ALARM holds regardless of enable or stream; only an
                    // acknowledge releases it, and it beats a same-cycle bit.
                    if (i_clear) begin
                        o_alarm    <= 1'b0;
                        o_miss_cnt <= '0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb/tb_lfsr_stream_checker.sv - scoreboard testbench for lfsr_stream_checker (NUM_BITS=16, ERR_THRESH=4)

module tb_lfsr_stream_checker;

    logic        clk;
    logic        i_rst_n;
    logic        i_Enable;
    logic        i_bit_valid;
    logic        i_bit;
    logic        i_clear;
    logic        o_locked;
    logic        o_alarm;
    logic [7:0]  o_miss_cnt;
    logic [15:0] o_LFSR_Data;

    lfsr_stream_checker #(
        .NUM_BITS   (16),
        .ERR_THRESH (4),
        .MISS_W     (8)
    ) dut (
        .i_Clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_Enable    (i_Enable),
        .i_bit_valid (i_bit_valid),
        .i_bit       (i_bit),
        .i_clear     (i_clear),
        .o_locked    (o_locked),
        .o_alarm     (o_alarm),
        .o_miss_cnt  (o_miss_cnt),
        .o_LFSR_Data (o_LFSR_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        locked;
        logic        alarm;
        logic [7:0]  miss;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   err_pos[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    logic chk    = 1'b0;

    // Expected outputs after the next edge
    logic        m_locked = 1'b0;
    logic        m_alarm  = 1'b0;
    logic [7:0]  m_miss   = '0;
    logic [15:0] m_data   = '0;

    function automatic void push(input string tag);
        exp_t e;
        e.tag    = tag;
        e.locked = m_locked;
        e.alarm  = m_alarm;
        e.miss   = m_miss;
        e.data   = m_data;
        q.push_back(e);
    endfunction

    function automatic bit is_err(input int idx);
        foreach (err_pos[k]) if (err_pos[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: whenever a checked cycle's edge occurs, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (chk) begin
                #2;
                n_tot++;
                if (q.size() == 0) begin
                    $display("FAIL scoreboard_empty: got no expected entry, required one");
                end else begin
                    e = q.pop_front();
                    if (o_locked === e.locked && o_alarm === e.alarm &&
                        o_miss_cnt === e.miss && o_LFSR_Data === e.data) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s: got locked=%0b alarm=%0b miss=%0d data=%h, required locked=%0b alarm=%0b miss=%0d data=%h",
                                 e.tag, o_locked, o_alarm, o_miss_cnt, o_LFSR_Data,
                                 e.locked, e.alarm, e.miss, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_tot + 1);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic en, input logic clr, input logic v, input logic b, input string tag);
        @(negedge clk);
        i_Enable    = en;
        i_clear     = clr;
        i_bit_valid = v;
        i_bit       = b;
        chk         = 1'b1;
        push(tag);
        @(negedge clk);
        chk         = 1'b0;
        i_clear     = 1'b0;
        i_bit_valid = 1'b0;
    endtask

    task automatic send(input logic b, input string tag);
        cyc(1'b1, 1'b0, 1'b1, b, tag);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst_n     = 1'b0;
        i_Enable    = 1'b0;
        i_bit_valid = 1'b0;
        i_clear     = 1'b0;
        m_locked = 1'b0; m_alarm = 1'b0; m_miss = '0; m_data = '0;
        chk = 1'b1;
        push("reset");
        @(negedge clk);
        chk     = 1'b0;
        i_rst_n = 1'b1;
    endtask

    // Drives the 16-bit generator stream (taps 16,15,13,4, XNOR), inverting
    // bits listed in err_pos, and predicts the checker response.
    task automatic run_stream(input logic [15:0] seed, input int n, input string tag);
        logic [15:0] g;
        logic        gb;
        logic        b;
        int          cnt;
        bit          used;
        g    = seed;
        cnt  = 0;
        used = 1'b0;
        for (int i = 0; i < n; i++) begin
            g  = {g[14:0], ~(g[15] ^ g[14] ^ g[12] ^ g[3])};
            gb = g[0];
            b  = gb ^ is_err(i);
            if (!m_alarm) begin
                if (!m_locked) begin
                    m_data = {m_data[14:0], b};
                    cnt++;
                    if (cnt == 16) m_locked = 1'b1;
                end else begin
                    m_data = {m_data[14:0], gb};
                    if (b != gb) begin
                        m_miss++;
                        if (m_miss == 8'd4) begin
                            m_locked = 1'b0;
`ifdef LFSR_RESYNC_EN
                            if (!used) begin
                                used   = 1'b1;
                                m_miss = '0;
                                cnt    = 0;
                            end else
`endif
                            begin
                                m_alarm = 1'b1;
                            end
                        end
                    end
                end
            end
            send(b, tag);
        end
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_Enable    = 1'b0;
        i_bit_valid = 1'b0;
        i_bit       = 1'b0;
        i_clear     = 1'b0;

        // Basic lock and track
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "idle_to_load");
        err_pos.delete();
        run_stream(16'hACE1, 200, "basic");

        // Single bit error, flywheel recovers
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "idle_to_load");
        err_pos = '{40};
        run_stream(16'hACE1, 100, "single_err");

        // Threshold alarm (with resync: first hit reloads, second alarms)
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "idle_to_load");
`ifdef LFSR_RESYNC_EN
        err_pos = '{20, 30, 50, 60, 90, 100, 110, 120};
        run_stream(16'hACE1, 150, "thresh_resync");
`else
        err_pos = '{20, 30, 50, 60};
        run_stream(16'hACE1, 80, "thresh");
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "alarm_ignores_enable");
        m_alarm = 1'b0;
        m_miss  = '0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, "clear_wins_over_bit");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "idle_to_load_after_clear");
        err_pos.delete();
        run_stream(16'h1234, 20, "relock_after_clear");

        // Stuck-at-1: loads all ones and alarms without ever locking
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "idle_to_load");
        for (int k = 1; k <= 16; k++) begin
            m_data = {m_data[14:0], 1'b1};
            if (k == 16) m_alarm = 1'b1;
            send(1'b1, "stuck1");
        end
        send(1'b0, "stuck1_ignored");

        // Stuck-at-0: all-zero is legal, locks, predicts 1 next
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "idle_to_load");
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) m_locked = 1'b1;
            send(1'b0, "stuck0_load");
        end
        m_miss = 8'd1;
        m_data = 16'h0001;
        send(1'b0, "stuck0_first_miss");
        m_data = 16'h0003;
        send(1'b1, "stuck0_match");

        // Reset during load, then fresh full lock
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "idle_to_load");
        err_pos.delete();
        run_stream(16'hACE1, 9, "load9");
        @(posedge clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        n_tot++;
        if (o_locked === 1'b0 && o_alarm === 1'b0 && o_miss_cnt === 8'd0 && o_LFSR_Data === 16'h0000)
            n_pass++;
        else
            $display("FAIL async_reset: got locked=%0b alarm=%0b miss=%0d data=%h, required all zero",
                     o_locked, o_alarm, o_miss_cnt, o_LFSR_Data);
        m_locked = 1'b0; m_alarm = 1'b0; m_miss = '0; m_data = '0;
        @(negedge clk);
        i_rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "idle_to_load_after_reset");
        run_stream(16'hBEEF, 40, "relock_after_reset");

        // Enable drop mid-LOCKED, then relock from fresh bits
        m_locked = 1'b0;
        m_miss   = '0;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "enable_drop");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "re_enable");
        run_stream(16'h5A5A, 30, "relock_after_enable");

        repeat (3) @(negedge clk);
        n_tot++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left, required 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
